// File: rtl/alu_pkg.sv
// Shared ALUFN encodings and the result bundle used by the execute stage.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  // alufn[5:4] operation classes
  localparam logic [1:0] ALU_ARITH = 2'b00;
  localparam logic [1:0] ALU_BOOL  = 2'b01;
  localparam logic [1:0] ALU_SHIFT = 2'b10;
  localparam logic [1:0] ALU_CMP   = 2'b11;

  // Named opcodes
  localparam logic [5:0] ADD   = 6'b000000;
  localparam logic [5:0] SUB   = 6'b000001;
  localparam logic [5:0] AND   = 6'b011000;
  localparam logic [5:0] OR    = 6'b011110;
  localparam logic [5:0] XOR   = 6'b010110;
  localparam logic [5:0] SHL   = 6'b100000;
  localparam logic [5:0] SHR   = 6'b100001;
  localparam logic [5:0] SRA   = 6'b100011;
  localparam logic [5:0] CMPEQ = 6'b110011;
  localparam logic [5:0] CMPLT = 6'b110101;
  localparam logic [5:0] CMPLE = 6'b110111;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] res;
    logic                 z;
    logic                 v;
    logic                 n;
  } alu_result_t;

endpackage

// File: rtl/alu_execute_stage_shifter.sv
// Existing combinational barrel shifter: SHL, SHR (logical), SRA; code 10 falls back to SHL.
module ShifterModule #(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       alufn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] amount;
  logic          unused_bits;

  assign amount      = b[SW-1:0];
  assign unused_bits = ^{alufn[5:2], b[WIDTH-1:SW]};

  // Select shift direction/kind from the low two alufn bits.
  always_comb begin
    res = a << amount;
    case (alufn[1:0])
      2'b01:   res = a >> amount;
      2'b11:   res = $signed(a) >>> amount;
      default: res = a << amount;
    endcase
  end

endmodule

// File: rtl/alu_skid_buf.sv
// Two-entry skid buffer: output register O plus skid register S; in_ready is purely registered.
module alu_skid_buf #(
  parameter int DW = 35
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          accept;
  logic          o_free;

  assign in_ready = !s_valid;
  assign accept   = in_valid && in_ready;
  assign o_free   = !out_valid || out_ready;

  // O refills from S first, otherwise from the input; a held O diverts new data into S.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      s_valid   <= 1'b0;
      s_data    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      s_valid   <= 1'b0;
      s_data    <= '0;
    end else if (o_free) begin
      if (s_valid) begin
        out_data  <= s_data;
        out_valid <= 1'b1;
        s_valid   <= 1'b0;
      end else if (accept) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      s_data  <= in_data;
      s_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_execute_stage.sv
// Registered ALU execute stage: full ALUFN set with adder flags, delivered through a skid buffer.
module alu_execute_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alufn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             z,
  output logic             v,
  output logic             n
);

  logic             adder_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] bool_res;
  logic [WIDTH-1:0] shift_res;
  logic [WIDTH-1:0] cmp_res;
  logic [WIDTH-1:0] alu_res;
  logic             flag_z;
  logic             flag_v;
  logic             flag_n;
  logic             cmp_lt;
  logic [WIDTH+2:0] op_bundle;
  logic [WIDTH+2:0] out_bundle;

  // Adder runs for every op so the flags always reflect it; compares force subtraction.
  always_comb begin
    adder_sub = (alufn[5:4] == ALU_CMP) || alufn[0];
    b_eff     = adder_sub ? ~b : b;
    sum       = a + b_eff + WIDTH'(adder_sub);
    flag_z    = (sum == '0);
    flag_n    = sum[WIDTH-1];
    flag_v    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    cmp_lt    = flag_n ^ flag_v;
  end

  // Boolean unit: each result bit looks up the 4-bit truth table in alufn[3:0].
  always_comb begin
    bool_res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bool_res[i] = alufn[{b[i], a[i]}];
    end
  end

  // Signed compares derived from the subtraction flags; code 00 yields zero.
  always_comb begin
    cmp_res = '0;
    case (alufn[2:1])
      2'b01:   cmp_res[0] = flag_z;
      2'b10:   cmp_res[0] = cmp_lt;
      2'b11:   cmp_res[0] = cmp_lt | flag_z;
      default: cmp_res[0] = 1'b0;
    endcase
  end

  // Final result select by operation class.
  always_comb begin
    alu_res = sum;
    case (alufn[5:4])
      ALU_ARITH: alu_res = sum;
      ALU_BOOL:  alu_res = bool_res;
      ALU_SHIFT: alu_res = shift_res;
      ALU_CMP:   alu_res = cmp_res;
      default:   alu_res = sum;
    endcase
  end

  ShifterModule #(.WIDTH(WIDTH)) u_shifter (
    .alufn (alufn),
    .a     (a),
    .b     (b),
    .res   (shift_res)
  );

  assign op_bundle       = {alu_res, flag_z, flag_v, flag_n};
  assign {res, z, v, n}  = out_bundle;

  alu_skid_buf #(.DW(WIDTH + 3)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (op_bundle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bundle)
  );

endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: directed vectors, random classes, backpressure, flush, reset.
module tb_alu_execute_stage;
  import alu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alufn;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        z;
  logic        v;
  logic        n;

  int vectors     = 0;
  int miscompares = 0;
  int accepted    = 0;

  alu_result_t sb_q[$];

  alu_execute_stage #(.WIDTH(ALU_WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alufn     (alufn),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .z         (z),
    .v         (v),
    .n         (n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model written from the ALUFN definitions using wide signed arithmetic.
  function automatic alu_result_t model(logic [5:0] f, logic [31:0] x, logic [31:0] y);
    alu_result_t r;
    logic        sub;
    longint      sx;
    longint      sy;
    longint      exact;
    logic [63:0] ex_bits;
    logic [31:0] sum;
    sub     = (f[5:4] == 2'b11) || f[0];
    sx      = longint'($signed(x));
    sy      = longint'($signed(y));
    exact   = sub ? (sx - sy) : (sx + sy);
    ex_bits = exact;
    sum     = ex_bits[31:0];
    r.z     = (sum == 32'd0);
    r.n     = sum[31];
    r.v     = (exact != longint'($signed(sum)));
    r.res   = sum;
    case (f[5:4])
      2'b01: for (int i = 0; i < 32; i++) r.res[i] = f[{y[i], x[i]}];
      2'b10: begin
        case (f[1:0])
          2'b01:   r.res = x >> y[4:0];
          2'b11:   r.res = $signed(x) >>> y[4:0];
          default: r.res = x << y[4:0];
        endcase
      end
      2'b11: begin
        case (f[2:1])
          2'b01:   r.res = {31'd0, sx == sy};
          2'b10:   r.res = {31'd0, sx < sy};
          2'b11:   r.res = {31'd0, sx <= sy};
          default: r.res = 32'd0;
        endcase
      end
      default: r.res = sum;
    endcase
    return r;
  endfunction

  // One clock: record drain/accept against the scoreboard, then step to just after the edge.
  task automatic advance(output logic drained, output alu_result_t got, output alu_result_t exp);
    drained = out_valid && out_ready && !flush;
    got.res = res;
    got.z   = z;
    got.v   = v;
    got.n   = n;
    exp     = 'x;
    if (drained && sb_q.size() > 0) exp = sb_q.pop_front();
    if (in_valid && in_ready && !flush) begin
      sb_q.push_back(model(alufn, a, b));
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alufn = 6'd0; a = 32'd0; b = 32'd0;
    #12;
    vectors++;
    if ({out_valid, res, z, v, n, in_ready} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_state got=%b_%h_%b%b%b_%b want=0_00000000_000_1",
               out_valid, res, z, v, n, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [5:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
    logic        fz;
    logic        fv;
    logic        fn;
    logic        chk_flags;
  } vec_t;

  task automatic test_directed();
    vec_t        tbl[$];
    logic        d;
    alu_result_t g;
    alu_result_t e;
    tbl.push_back('{"SHL",    SHL,     32'h87654321, 32'h00000004, 32'h76543210, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"SRA",    SRA,     32'h87654321, 32'h00000004, 32'hF8765432, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"SHR",    SHR,     32'h87654321, 32'h00000004, 32'h08765432, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"SRA31",  SRA,     32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"SHLAMT", SHL,     32'h00000001, 32'h00000024, 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"ADDOVF", ADD,     32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{"ADDWRAP",ADD,     32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{"SUBZ",   SUB,     32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{"SUBOVF", SUB,     32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{"CMPLT",  CMPLT,   32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{"CMPLE",  CMPLE,   32'h00000003, 32'h00000003, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"CMPEQ",  CMPEQ,   32'h00000003, 32'h00000004, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"CMPRSV", 6'b110001, 32'h00000003, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"AND",    AND,     32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"OR",     OR,      32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"XOR",    XOR,     32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{"PASSA",  6'b011010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0, 1'b0});
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      alufn = tbl[i].f; a = tbl[i].x; b = tbl[i].y; in_valid = 1'b1;
      advance(d, g, e);
      if (d) begin
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("[TB] FAIL sb_directed got=%h exp=%h", g, e);
        end
      end
      vectors++;
      if (out_valid !== 1'b1 || res !== tbl[i].r ||
          (tbl[i].chk_flags && {z, v, n} !== {tbl[i].fz, tbl[i].fv, tbl[i].fn})) begin
        miscompares++;
        $display("[TB] FAIL %s got=%b_%h_%b%b%b want=1_%h_%b%b%b", tbl[i].name, out_valid, res,
                 z, v, n, tbl[i].r, tbl[i].fz, tbl[i].fv, tbl[i].fn);
      end
    end
    in_valid = 1'b0;
    advance(d, g, e);
    vectors++;
    if (!d || g !== e) begin
      miscompares++;
      $display("[TB] FAIL sb_directed_last drained=%b got=%h exp=%h", d, g, e);
    end
  endtask

  task automatic test_random_class(input string tag, input logic [1:0] cls, input int count);
    logic        d;
    logic        taken;
    int          acc0;
    alu_result_t g;
    alu_result_t e;
    for (int i = 0; i < count; i++) begin
      alufn = {cls, 4'($urandom)};
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      in_valid = 1'b1;
      taken = 1'b0;
      for (int t = 0; t < 8 && !taken; t++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        acc0 = accepted;
        advance(d, g, e);
        taken = (accepted != acc0);
        if (d) begin
          vectors++;
          if (g !== e) begin
            miscompares++;
            $display("[TB] FAIL sb_%s got=%h exp=%h", tag, g, e);
          end
        end
      end
      if (!taken) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL accept_%s in_ready=%b required=1", tag, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 6 && sb_q.size() > 0; t++) begin
      advance(d, g, e);
      if (d) begin
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("[TB] FAIL sb_%s got=%h exp=%h", tag, g, e);
        end
      end
    end
    vectors++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL drain_%s pending=%0d out_valid=%b required 0/0", tag, sb_q.size(), out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic        d;
    int          acc0;
    int          drains;
    alu_result_t g;
    alu_result_t e;
    out_ready = 1'b0;
    alufn = ADD;
    for (int i = 0; i < 2; i++) begin
      a = i; b = 32'd1; in_valid = 1'b1;
      advance(d, g, e);
    end
    a = 32'd2; b = 32'd1;
    for (int t = 0; t < 3; t++) begin
      vectors++;
      if ({in_ready, out_valid, res} !== {1'b0, 1'b1, 32'd1}) begin
        miscompares++;
        $display("[TB] FAIL stall got in_ready=%b out_valid=%b res=%h want 0 1 00000001",
                 in_ready, out_valid, res);
      end
      advance(d, g, e);
    end
    out_ready = 1'b1;
    drains = 0;
    for (int t = 0; t < 10 && (in_valid || sb_q.size() > 0); t++) begin
      acc0 = accepted;
      advance(d, g, e);
      if (accepted != acc0) in_valid = 1'b0;
      if (d) begin
        drains++;
        vectors++;
        if (g.res !== drains || g !== e) begin
          miscompares++;
          $display("[TB] FAIL sb_backpressure got=%h exp=%h order=%0d", g, e, drains);
        end
      end
    end
    vectors++;
    if (drains != 3 || out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL backpressure_count got=%0d required=3", drains);
    end
  endtask

  task automatic test_back_to_back();
    logic        d;
    int          acc0;
    alu_result_t g;
    alu_result_t e;
    out_ready = 1'b1;
    acc0 = accepted;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        alufn = ($urandom_range(0, 1) != 0) ? SUB : ADD;
        a = $urandom; b = $urandom; in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || (i > 0 && out_valid !== 1'b1)) begin
          miscompares++;
          $display("[TB] FAIL stream_ready got in_ready=%b out_valid=%b cycle=%0d want 1 1", in_ready, out_valid, i);
        end
      end else begin
        in_valid = 1'b0;
      end
      advance(d, g, e);
      if (d) begin
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("[TB] FAIL sb_stream got=%h exp=%h", g, e);
        end
      end
    end
    vectors++;
    if (accepted - acc0 != 8 || sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stream_count got=%0d pending=%0d required=8/0", accepted - acc0, sb_q.size());
    end
  endtask

  task automatic test_flush();
    logic        d;
    alu_result_t g;
    alu_result_t e;
    out_ready = 1'b0;
    alufn = ADD;
    for (int i = 0; i < 2; i++) begin
      a = 32'h100 + i; b = 32'd1; in_valid = 1'b1;
      advance(d, g, e);
    end
    flush = 1'b1; a = 32'h200;
    advance(d, g, e);
    flush = 1'b0; in_valid = 1'b0;
    sb_q.delete();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL flush got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      advance(d, g, e);
      vectors++;
      if (out_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL flush_leak out_valid=%b required=0", out_valid);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic        d;
    alu_result_t g;
    alu_result_t e;
    out_ready = 1'b0;
    alufn = SUB;
    for (int i = 0; i < 2; i++) begin
      a = 32'h50 + i; b = 32'd7; in_valid = 1'b1;
      advance(d, g, e);
    end
    #3;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, res, z, v, n, in_ready} !== {1'b0, 32'd0, 3'b000, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL async_reset got=%b_%h_%b%b%b_%b want=0_00000000_000_1",
               out_valid, res, z, v, n, in_ready);
    end
    sb_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    alufn = ADD; a = 32'd40; b = 32'd2; in_valid = 1'b1;
    advance(d, g, e);
    in_valid = 1'b0;
    advance(d, g, e);
    vectors++;
    if (!d || g !== e || g.res !== 32'd42) begin
      miscompares++;
      $display("[TB] FAIL post_reset drained=%b got=%h exp=%h", d, g, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_class("arith", ALU_ARITH, 20);
    test_random_class("bool",  ALU_BOOL,  20);
    test_random_class("shift", ALU_SHIFT, 20);
    test_random_class("cmp",   ALU_CMP,   20);
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
